snax_tcdm_port_arbiter: RTL

//  Shares one TCDM reqrsp port between NumInp accelerator-side reqrsp requesters
//  (e.g. several HWPE-to-reqrsp bridges). Round-robin arbitration with grant lock

---
 rtl/snax_tcdm_arb_pkg.sv | 64 ++++++
 rtl/snax_rr_lock_arbiter.sv | 73 +++++++
 rtl/snax_tcdm_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/snax_tcdm_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snax_tcdm_arb_pkg : shared types and helpers for the TCDM port arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package snax_tcdm_arb_pkg;

    localparam int unsigned AddrWidth     = 32;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned StrbWidth     = DataWidth / 8;
    localparam int unsigned NumInpDefault = 4;

    typedef logic [$clog2(NumInpDefault)-1:0] idx_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [3:0]           amo;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_rsp_chan_t p;
        logic           p_valid;
        logic           q_ready;
    } tcdm_rsp_t;

    // Counter must hold the value max_out itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out) + 1;
    endfunction

    // First set bit of valid strictly after ptr, wrapping over n entries.
    function automatic int unsigned rr_pick(input logic [31:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= 32; k++) begin
            int unsigned idx;
            idx = (ptr + k) % n;
            if (k <= n && !found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snax_rr_lock_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snax_rr_lock_arbiter : round-robin pick with grant lock on stalled requests
// Revision: 1.0
// ---------------------------------------------------------------------------
module snax_rr_lock_arbiter
    import snax_tcdm_arb_pkg::*;
#(
    parameter int unsigned NumInp = 4,
    parameter int unsigned IdxW   = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumInp-1:0] valid_i,
    input  logic              ready_i,
    input  logic              block_i,
    output logic              gnt_valid_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              handshake_o,
    output logic              lock_drop_o
);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            locked_q, locked_d;
    logic [IdxW-1:0] winner;
    logic            gnt_valid;
    logic            handshake;
    logic            lock_drop;

    always_comb begin
        winner = locked_q ? lock_idx_q
                          : IdxW'(rr_pick(32'(valid_i), 32'(rr_ptr_q), NumInp));
    end

    assign gnt_valid   = ~block_i & valid_i[winner];
    assign handshake   = gnt_valid & ready_i;
    assign lock_drop   = locked_q & ~valid_i[lock_idx_q];
    assign gnt_valid_o = gnt_valid;
    assign gnt_idx_o   = winner;
    assign handshake_o = handshake;
    assign lock_drop_o = lock_drop;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            rr_ptr_d = winner;
            locked_d = 1'b0;
        end else if (gnt_valid) begin
            // Stalled request: pin the grant so the offered payload stays stable.
            locked_d   = 1'b1;
            lock_idx_d = winner;
        end else if (lock_drop) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= IdxW'(NumInp - 1);
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snax_tcdm_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snax_tcdm_port_arbiter : N reqrsp requesters onto one TCDM port, in-order rsp
// Revision: 1.0
// ---------------------------------------------------------------------------
module snax_tcdm_port_arbiter
    import snax_tcdm_arb_pkg::*;
#(
    parameter int unsigned NumInp         = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter type tcdm_req_t             = snax_tcdm_arb_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t             = snax_tcdm_arb_pkg::tcdm_rsp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  tcdm_req_t                             inp_req_i [NumInp],
    output tcdm_rsp_t                             inp_rsp_o [NumInp],
    output tcdm_req_t                             oup_req_o,
    input  tcdm_rsp_t                             oup_rsp_i,
    output logic                                  busy_o,
    output logic [$clog2(MaxOutstanding):0]       outstanding_o
);

    localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = cnt_width(MaxOutstanding);

    typedef logic [IdxW-1:0] id_t;

    logic [NumInp-1:0] valid;
    logic              gnt_valid;
    id_t               gnt_idx;
    logic              handshake;
    logic              lock_drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    id_t               id_mem_q [MaxOutstanding];

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            valid[i] = inp_req_i[i].q_valid;
        end
    end

    // Occupancy is taken from the registered count only, so a pop cannot free
    // a slot for a push in the same cycle.
    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = oup_rsp_i.p_valid & ~fifo_empty;

    snax_rr_lock_arbiter #(
        .NumInp (NumInp),
        .IdxW   (IdxW)
    ) i_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid),
        .ready_i     (oup_rsp_i.q_ready),
        .block_i     (fifo_full),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .handshake_o (handshake),
        .lock_drop_o (lock_drop)
    );

    always_comb begin
        oup_req_o         = '0;
        oup_req_o.q       = inp_req_i[gnt_idx].q;
        oup_req_o.q_valid = gnt_valid;
        for (int i = 0; i < NumInp; i++) begin
            inp_rsp_o[i]         = '0;
            inp_rsp_o[i].p.data  = oup_rsp_i.p.data;
            inp_rsp_o[i].q_ready = gnt_valid & oup_rsp_i.q_ready & (gnt_idx == id_t'(i));
            inp_rsp_o[i].p_valid = pop & (id_mem_q[rd_ptr_q] == id_t'(i));
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (handshake) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (handshake && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !handshake) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0) | gnt_valid;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(oup_rsp_i.p_valid && fifo_empty))
                else $warning("response received with no request outstanding, dropped");
            assert (!lock_drop)
                else $warning("locked requester withdrew q_valid before acceptance");
        end
    end
`endif

endmodule
`default_nettype wire
